// File: rtl/ins_decoder_if.sv
// Instruction stream plus load/save command channels around ins_decoder.
// master = fetch FIFO and DDR units; slave = the decoder.
interface ins_decoder_if;
    logic        ins_valid;
    logic        ins_ready;
    logic [63:0] ins;

    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_op;
    logic [2:0]  rd_layer;
    logic [15:0] rd_len;
    logic [31:0] rd_addr;
    logic        rd_done;

    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_op;
    logic [2:0]  wr_layer;
    logic [15:0] wr_len;
    logic [31:0] wr_addr;
    logic        wr_done;

    modport master (
        output ins_valid, ins, rd_ready, rd_done, wr_ready, wr_done,
        input  ins_ready,
        input  rd_valid, rd_op, rd_layer, rd_len, rd_addr,
        input  wr_valid, wr_op, wr_layer, wr_len, wr_addr
    );

    modport slave (
        input  ins_valid, ins, rd_ready, rd_done, wr_ready, wr_done,
        output ins_ready,
        output rd_valid, rd_op, rd_layer, rd_len, rd_addr,
        output wr_valid, wr_op, wr_layer, wr_len, wr_addr
    );
endinterface

// File: rtl/ins_decoder.sv
// Decodes 64-bit instruction words into load/save commands, tracks outstanding
// transfers per unit, enforces SYNC barriers and latches the first error seen.
module ins_decoder #(
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    ins_decoder_if.slave bus,
    output logic [2:0]   layer_type,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    localparam logic [1:0] CLS_CFG  = 2'b00;
    localparam logic [1:0] CLS_RD   = 2'b01;
    localparam logic [1:0] CLS_WR   = 2'b10;
    localparam logic [3:0] SYNC_OP  = 4'b1111;

    localparam logic [2:0] LT_F_CONV = 3'b000;
    localparam logic [2:0] LT_LAST   = 3'b101;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OP    = 2'd1;
    localparam logic [1:0] ERR_UFLOW = 2'd2;
    localparam logic [1:0] ERR_LT    = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR, SYNC} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  layer;
        logic [15:0] len;
        logic [31:0] addr;
    } cmd_t;

    function automatic logic rd_op_ok(input logic [3:0] o);
        return o inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    endfunction

    function automatic logic wr_op_ok(input logic [3:0] o);
        return o inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    endfunction

    state_t        state_q, state_d;
    cmd_t          rd_cmd_q, rd_cmd_d, wr_cmd_q, wr_cmd_d;
    logic          rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d, dec_err;
    logic [2:0]    lt_q, lt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    // instruction word fields
    logic [1:0]  ins_cls;
    logic [3:0]  ins_op;
    logic [2:0]  ins_lt;
    cmd_t        ins_cmd;
    logic        unused_rsvd;

    assign ins_cls     = bus.ins[63:62];
    assign ins_op      = bus.ins[61:58];
    assign ins_lt      = bus.ins[57:55];
    assign ins_cmd     = '{op: ins_op, layer: lt_q, len: bus.ins[47:32], addr: bus.ins[31:0]};
    assign unused_rsvd = ^bus.ins[54:48];

    // rdy_q is only ever high while the FSM sits in IDLE
    logic accept;
    assign accept = rdy_q & bus.ins_valid;

    logic rd_hs, wr_hs, rd_dec, wr_dec, rd_uflow, wr_uflow;
    assign rd_hs    = rd_vld_q & bus.rd_ready;
    assign wr_hs    = wr_vld_q & bus.wr_ready;
    // a done arriving with the handshake that refills the slot just cancels it out
    assign rd_dec   = bus.rd_done & ((rd_cnt_q != '0) | rd_hs);
    assign wr_dec   = bus.wr_done & ((wr_cnt_q != '0) | wr_hs);
    assign rd_uflow = bus.rd_done & (rd_cnt_q == '0) & ~rd_hs;
    assign wr_uflow = bus.wr_done & (wr_cnt_q == '0) & ~wr_hs;

    assign rd_cnt_d = rd_cnt_q + CW'(rd_hs) - CW'(rd_dec);
    assign wr_cnt_d = wr_cnt_q + CW'(wr_hs) - CW'(wr_dec);

    always_comb begin
        state_d  = state_q;
        rd_cmd_d = rd_cmd_q;
        wr_cmd_d = wr_cmd_q;
        lt_d     = lt_q;
        dec_err  = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (ins_cls)
                        CLS_CFG: begin
                            if (ins_lt <= LT_LAST) lt_d = ins_lt;
                            else                   dec_err = ERR_LT;
                        end
                        CLS_RD: begin
                            if (rd_op_ok(ins_op)) begin
                                rd_cmd_d = ins_cmd;
                                state_d  = ISSUE_RD;
                            end else begin
                                dec_err = ERR_OP;
                            end
                        end
                        CLS_WR: begin
                            if (wr_op_ok(ins_op)) begin
                                wr_cmd_d = ins_cmd;
                                state_d  = ISSUE_WR;
                            end else begin
                                dec_err = ERR_OP;
                            end
                        end
                        default: begin
                            if (ins_op == SYNC_OP) state_d = SYNC;
                            else                   dec_err = ERR_OP;
                        end
                    endcase
                end
            end
            ISSUE_RD: if (rd_hs) state_d = IDLE;
            ISSUE_WR: if (wr_hs) state_d = IDLE;
            SYNC:     if ((rd_cnt_q == '0) && (wr_cnt_q == '0)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // valid is withheld while the unit already has MAX_OUT transfers in flight
    always_comb begin
        rd_vld_d = (state_d == ISSUE_RD) && (rd_cnt_d < MAX_CNT);
        wr_vld_d = (state_d == ISSUE_WR) && (wr_cnt_d < MAX_CNT);
        rdy_d    = (state_d == IDLE);
        busy_d   = (state_d != IDLE) || (rd_cnt_d != '0) || (wr_cnt_d != '0);
    end

    // first error wins; instruction errors take precedence over a same-cycle underflow
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (!err_q) begin
            if (dec_err != ERR_NONE) begin
                err_d  = 1'b1;
                code_d = dec_err;
            end else if (rd_uflow || wr_uflow) begin
                err_d  = 1'b1;
                code_d = ERR_UFLOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_vld_q <= 1'b0;
            rd_cmd_q <= '0;
            wr_cmd_q <= '0;
            lt_q     <= LT_F_CONV;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            rd_vld_q <= rd_vld_d;
            wr_vld_q <= wr_vld_d;
            rd_cmd_q <= rd_cmd_d;
            wr_cmd_q <= wr_cmd_d;
            lt_q     <= lt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign bus.ins_ready = rdy_q;

    assign bus.rd_valid  = rd_vld_q;
    assign bus.rd_op     = rd_cmd_q.op;
    assign bus.rd_layer  = rd_cmd_q.layer;
    assign bus.rd_len    = rd_cmd_q.len;
    assign bus.rd_addr   = rd_cmd_q.addr;

    assign bus.wr_valid  = wr_vld_q;
    assign bus.wr_op     = wr_cmd_q.op;
    assign bus.wr_layer  = wr_cmd_q.layer;
    assign bus.wr_len    = wr_cmd_q.len;
    assign bus.wr_addr   = wr_cmd_q.addr;

    assign layer_type = lt_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = code_q;
endmodule

// File: tb/tb_ins_decoder.sv
// Bench for ins_decoder: directed timing scenarios plus a randomized run
// compared against a transaction-level model of dispatched commands.
module tb_ins_decoder;
    localparam int MAX_OUT = 4;
    localparam logic [1:0] C_CFG = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_SYNC = 2'b11;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  layer;
        logic [15:0] len;
        logic [31:0] addr;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] layer_type;
    logic       busy, err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ins_decoder_if bus();

    ins_decoder #(.MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .layer_type(layer_type), .busy(busy), .err(err), .err_code(err_code)
    );

    // ready/done come either from the directed tests or from the random driver
    logic rnd_mode = 1'b0;
    logic d_rd_ready = 1'b0, d_rd_done = 1'b0, d_wr_ready = 1'b0, d_wr_done = 1'b0;
    logic r_rd_ready = 1'b0, r_rd_done = 1'b0, r_wr_ready = 1'b0, r_wr_done = 1'b0;
    assign bus.rd_ready = rnd_mode ? r_rd_ready : d_rd_ready;
    assign bus.rd_done  = rnd_mode ? r_rd_done  : d_rd_done;
    assign bus.wr_ready = rnd_mode ? r_wr_ready : d_wr_ready;
    assign bus.wr_done  = rnd_mode ? r_wr_done  : d_wr_done;

    // observed command stream and outstanding counts
    cmd_t cap_rd[$], cap_wr[$];
    int out_rd = 0, out_wr = 0;

    always @(posedge clk) begin
        if (!rst) begin
            out_rd <= 0;
            out_wr <= 0;
        end else begin
            if (bus.rd_valid && bus.rd_ready)
                cap_rd.push_back('{bus.rd_op, bus.rd_layer, bus.rd_len, bus.rd_addr});
            if (bus.wr_valid && bus.wr_ready)
                cap_wr.push_back('{bus.wr_op, bus.wr_layer, bus.wr_len, bus.wr_addr});
            out_rd <= out_rd + int'(bus.rd_valid && bus.rd_ready) - int'(bus.rd_done);
            out_wr <= out_wr + int'(bus.wr_valid && bus.wr_ready) - int'(bus.wr_done);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            r_rd_ready = ($urandom_range(0, 2) != 0);
            r_wr_ready = ($urandom_range(0, 2) != 0);
            r_rd_done  = (out_rd > 0) && ($urandom_range(0, 2) == 0);
            r_wr_done  = (out_wr > 0) && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] mk(input logic [1:0] c, input logic [3:0] o,
                                       input logic [2:0] l, input logic [15:0] n,
                                       input logic [31:0] a);
        return {c, o, l, 7'd0, n, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns in the cycle right after the accepting edge
    task automatic send(input logic [63:0] w);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.ins_ready === 1'b1) begin
                bus.ins = w;
                bus.ins_valid = 1'b1;
                tick();
                bus.ins_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: ins_ready never rose for word %016h", w);
        end
    endtask

    task automatic pulse_rd_done();
        d_rd_done = 1'b1; tick(); d_rd_done = 1'b0;
    endtask

    task automatic pulse_wr_done();
        d_wr_done = 1'b1; tick(); d_wr_done = 1'b0;
    endtask

    task automatic do_reset();
        rnd_mode = 1'b0;
        bus.ins_valid = 1'b0; bus.ins = '0;
        d_rd_ready = 1'b0; d_rd_done = 1'b0; d_wr_ready = 1'b0; d_wr_done = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        send(mk(C_CFG, 4'd0, 3'b010, 16'd0, 32'd0));
        send(mk(C_RD, 4'b0001, 3'b000, 16'h0010, 32'h0000_0ABC));
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0h want 1", bus.rd_valid); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL rst_ins_ready: got %0h want 0", bus.ins_ready); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL rst_valids: got rd=%0h wr=%0h want 0", bus.rd_valid, bus.wr_valid); end
        checks++; if ({bus.rd_op, bus.rd_layer, bus.rd_len, bus.rd_addr} !== 55'd0) begin errors++; $display("FAIL rst_rd_fields: got op=%0h addr=%0h want 0", bus.rd_op, bus.rd_addr); end
        checks++; if ({bus.wr_op, bus.wr_layer, bus.wr_len, bus.wr_addr} !== 55'd0) begin errors++; $display("FAIL rst_wr_fields: got op=%0h addr=%0h want 0", bus.wr_op, bus.wr_addr); end
        checks++; if (layer_type !== 3'b000) begin errors++; $display("FAIL rst_layer: got %0h want 0", layer_type); end
        checks++; if ({busy, err, err_code} !== 4'd0) begin errors++; $display("FAIL rst_status: got busy=%0h err=%0h code=%0h want 0", busy, err, err_code); end
        rst = 1'b1;
        tick();
        checks++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0h want 1", bus.ins_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %0h want 0", busy); end
    endtask

    task automatic test_cfg_rd();
        do_reset();
        d_rd_ready = 1'b1;
        send(mk(C_CFG, 4'd0, 3'b011, 16'd0, 32'd0));
        checks++; if (layer_type !== 3'b011) begin errors++; $display("FAIL cfg_layer: got %0h want 3", layer_type); end
        send(mk(C_RD, 4'b0110, 3'b000, 16'd64, 32'h0000_1000));
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL cfg_rd_valid: got %0h want 1", bus.rd_valid); end
        checks++; if (bus.rd_layer !== 3'b011) begin errors++; $display("FAIL cfg_rd_layer: got %0h want 3", bus.rd_layer); end
        checks++; if ({bus.rd_op, bus.rd_len, bus.rd_addr} !== {4'b0110, 16'd64, 32'h1000}) begin errors++; $display("FAIL cfg_rd_fields: got op=%0h len=%0h addr=%0h want 6/40/1000", bus.rd_op, bus.rd_len, bus.rd_addr); end
        checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL cfg_rd_ins_ready: got %0h want 0", bus.ins_ready); end
        tick();
        checks++; if ({bus.rd_valid, bus.ins_ready, busy} !== 3'b011) begin errors++; $display("FAIL cfg_rd_after_hs: got valid/ready/busy=%03b want 011", {bus.rd_valid, bus.ins_ready, busy}); end
        pulse_rd_done();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_rd_drained: got busy=%0h want 0", busy); end
    endtask

    task automatic test_illegal();
        do_reset();
        d_rd_ready = 1'b1; d_wr_ready = 1'b1;
        send(mk(C_RD, 4'b0011, 3'b000, 16'd4, 32'h0000_0400));
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ill_rd_valid: got %0h want 0", bus.rd_valid); end
        checks++; if ({err, err_code} !== 3'b101) begin errors++; $display("FAIL ill_err: got err=%0h code=%0h want 1/1", err, err_code); end
        checks++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got %0h want 1", bus.ins_ready); end
        send(mk(C_WR, 4'b0010, 3'b000, 16'd8, 32'h0000_2000));
        checks++; if ({bus.wr_valid, bus.wr_op, bus.wr_addr} !== {1'b1, 4'b0010, 32'h2000}) begin errors++; $display("FAIL ill_next_wr: got valid=%0h op=%0h addr=%0h want 1/2/2000", bus.wr_valid, bus.wr_op, bus.wr_addr); end
        tick();
        pulse_wr_done();
        send(mk(C_SYNC, 4'b0111, 3'b000, 16'd0, 32'd0));
        checks++; if ({bus.ins_ready, err_code} !== 3'b101) begin errors++; $display("FAIL ill_sync_op: got ready=%0h code=%0h want 1/1", bus.ins_ready, err_code); end
    endtask

    task automatic test_max_out();
        do_reset();
        d_rd_ready = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin
            send(mk(C_RD, 4'b0000, 3'b000, 16'd1, 32'(i * 32'h100)));
            checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL max_fill%0d: got %0h want 1", i, bus.rd_valid); end
            tick();
        end
        send(mk(C_RD, 4'b0000, 3'b000, 16'd1, 32'h0000_0500));
        for (int c = 0; c < 3; c++) begin
            checks++; if ({bus.rd_valid, bus.ins_ready} !== 2'b00) begin errors++; $display("FAIL max_hold%0d: got valid/ready=%02b want 00", c, {bus.rd_valid, bus.ins_ready}); end
            tick();
        end
        pulse_rd_done();
        checks++; if ({bus.rd_valid, bus.rd_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL max_release: got valid=%0h addr=%0h want 1/500", bus.rd_valid, bus.rd_addr); end
        tick();
        for (int i = 0; i < MAX_OUT; i++) pulse_rd_done();
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL max_drain: got busy=%0h err=%0h want 0/0", busy, err); end
    endtask

    task automatic test_sync();
        do_reset();
        d_rd_ready = 1'b1; d_wr_ready = 1'b1;
        send(mk(C_RD, 4'b0001, 3'b000, 16'd2, 32'h10)); tick();
        send(mk(C_RD, 4'b0010, 3'b000, 16'd2, 32'h20)); tick();
        send(mk(C_WR, 4'b0011, 3'b000, 16'd2, 32'h30)); tick();
        send(mk(C_SYNC, 4'b1111, 3'b000, 16'd0, 32'd0));
        checks++; if ({bus.ins_ready, busy} !== 2'b01) begin errors++; $display("FAIL sync_enter: got ready/busy=%02b want 01", {bus.ins_ready, busy}); end
        bus.ins = mk(C_RD, 4'b0100, 3'b000, 16'd3, 32'h0000_0777);
        bus.ins_valid = 1'b1;
        tick(); tick();
        checks++; if ({bus.ins_ready, bus.rd_valid} !== 2'b00) begin errors++; $display("FAIL sync_block: got ready/rd_valid=%02b want 00", {bus.ins_ready, bus.rd_valid}); end
        pulse_rd_done();
        pulse_rd_done();
        checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL sync_wr_pending: got %0h want 0", bus.ins_ready); end
        pulse_wr_done();
        checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL sync_exit_early: got %0h want 0", bus.ins_ready); end
        tick();
        checks++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL sync_exit: got %0h want 1", bus.ins_ready); end
        tick();
        bus.ins_valid = 1'b0;
        checks++; if ({bus.rd_valid, bus.rd_addr} !== {1'b1, 32'h777}) begin errors++; $display("FAIL sync_after_rd: got valid=%0h addr=%0h want 1/777", bus.rd_valid, bus.rd_addr); end
        tick();
        pulse_rd_done();
        send(mk(C_SYNC, 4'b1111, 3'b000, 16'd0, 32'd0));
        checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL sync_min_cycle: got %0h want 0", bus.ins_ready); end
        tick();
        checks++; if ({bus.ins_ready, busy, err} !== 3'b100) begin errors++; $display("FAIL sync_empty_exit: got ready/busy/err=%03b want 100", {bus.ins_ready, busy, err}); end
    endtask

    task automatic test_stall();
        do_reset();
        send(mk(C_RD, 4'b0101, 3'b000, 16'h0020, 32'hDEAD_0000));
        for (int c = 0; c < 3; c++) begin
            checks++; if ({bus.rd_valid, bus.ins_ready, bus.rd_op, bus.rd_len, bus.rd_addr} !== {2'b10, 4'b0101, 16'h0020, 32'hDEAD_0000}) begin
                errors++; $display("FAIL stall_hold%0d: got v=%0h r=%0h op=%0h len=%0h addr=%0h", c, bus.rd_valid, bus.ins_ready, bus.rd_op, bus.rd_len, bus.rd_addr);
            end
            tick();
        end
        d_rd_ready = 1'b1;
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL stall_4th_valid: got %0h want 1", bus.rd_valid); end
        tick();
        checks++; if ({bus.rd_valid, bus.ins_ready} !== 2'b01) begin errors++; $display("FAIL stall_hs: got valid/ready=%02b want 01", {bus.rd_valid, bus.ins_ready}); end
        pulse_rd_done();
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_rd_ready = 1'b1;
        send(mk(C_CFG, 4'd0, 3'b100, 16'd0, 32'd0));
        checks++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL b2b_cfg_ready: got %0h want 1", bus.ins_ready); end
        send(mk(C_RD, 4'b0111, 3'b000, 16'd5, 32'h0000_0A00));
        checks++; if ({bus.rd_valid, bus.rd_layer} !== {1'b1, 3'b100}) begin errors++; $display("FAIL b2b_layer: got valid=%0h layer=%0h want 1/4", bus.rd_valid, bus.rd_layer); end
        tick();
        send(mk(C_RD, 4'b0000, 3'b000, 16'd6, 32'h0000_0B00));
        d_rd_done = 1'b1;
        tick();
        d_rd_done = 1'b0;
        checks++; if ({bus.rd_valid, busy, err} !== 3'b010) begin errors++; $display("FAIL b2b_hs_done: got valid/busy/err=%03b want 010", {bus.rd_valid, busy, err}); end
        pulse_rd_done();
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL b2b_drain: got busy/err=%02b want 00", {busy, err}); end
    endtask

    task automatic test_underflow();
        do_reset();
        pulse_rd_done();
        checks++; if ({err, err_code, busy} !== 4'b1100) begin errors++; $display("FAIL uf_rd: got err=%0h code=%0h busy=%0h want 1/2/0", err, err_code, busy); end
        send(mk(C_RD, 4'b1000, 3'b000, 16'd0, 32'd0));
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL uf_sticky: got %0h want 2", err_code); end
        send(mk(C_CFG, 4'd0, 3'b101, 16'd0, 32'd0));
        checks++; if (layer_type !== 3'b101) begin errors++; $display("FAIL uf_cfg5: got %0h want 5", layer_type); end
        send(mk(C_CFG, 4'd0, 3'b111, 16'd0, 32'd0));
        checks++; if ({layer_type, err_code} !== {3'b101, 2'd2}) begin errors++; $display("FAIL uf_cfg7: got layer=%0h code=%0h want 5/2", layer_type, err_code); end
        do_reset();
        pulse_wr_done();
        checks++; if ({err, err_code} !== 3'b110) begin errors++; $display("FAIL uf_wr: got err=%0h code=%0h want 1/2", err, err_code); end
        do_reset();
        send(mk(C_CFG, 4'd0, 3'b110, 16'd0, 32'd0));
        checks++; if ({layer_type, err, err_code} !== {3'b000, 1'b1, 2'd3}) begin errors++; $display("FAIL bad_lt: got layer=%0h err=%0h code=%0h want 0/1/3", layer_type, err, err_code); end
    endtask

    task automatic test_random();
        cmd_t exp_rd[$], exp_wr[$];
        logic [2:0] layer_m = 3'b000;
        logic [1:0] code_m = 2'd0;
        do_reset();
        cap_rd.delete(); cap_wr.delete();
        rnd_mode = 1'b1;
        for (int k = 0; k < 120; k++) begin
            int sel = int'($urandom_range(0, 9));
            logic [3:0]  op = 4'($urandom_range(0, 15));
            logic [2:0]  lt = 3'($urandom_range(0, 7));
            logic [15:0] len = 16'($urandom);
            logic [31:0] addr = $urandom;
            logic [1:0]  cls;
            if (sel < 2) begin
                cls = C_CFG;
                if (lt <= 3'd5) layer_m = lt;
                else if (code_m == 2'd0) code_m = 2'd3;
            end else if (sel < 5) begin
                cls = C_RD;
                if (op inside {0, 1, 2, 4, 5, 6, 7}) exp_rd.push_back('{op, layer_m, len, addr});
                else if (code_m == 2'd0) code_m = 2'd1;
            end else if (sel < 8) begin
                cls = C_WR;
                if (op inside {0, 2, 3, 4, 5}) exp_wr.push_back('{op, layer_m, len, addr});
                else if (code_m == 2'd0) code_m = 2'd1;
            end else begin
                cls = C_SYNC;
                if ($urandom_range(0, 3) != 0) op = 4'hF;
                if (op != 4'hF && code_m == 2'd0) code_m = 2'd1;
            end
            send(mk(cls, op, lt, len, addr));
        end
        begin
            bit drained = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (out_rd == 0 && out_wr == 0 && bus.ins_ready === 1'b1 && !bus.rd_done && !bus.wr_done) begin
                    drained = 1'b1;
                    break;
                end
                tick();
            end
            rnd_mode = 1'b0;
            checks++; if (!drained) begin errors++; $display("FAIL rnd_drain: got out_rd=%0d out_wr=%0d want 0/0", out_rd, out_wr); end
        end
        tick();
        checks++; if (cap_rd.size() != exp_rd.size()) begin errors++; $display("FAIL rnd_rd_count: got %0d want %0d", cap_rd.size(), exp_rd.size()); end
        checks++; if (cap_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rnd_wr_count: got %0d want %0d", cap_wr.size(), exp_wr.size()); end
        for (int i = 0; i < cap_rd.size() && i < exp_rd.size(); i++) begin
            checks++; if (cap_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL rnd_rd[%0d]: got %0h want %0h", i, cap_rd[i], exp_rd[i]); end
        end
        for (int i = 0; i < cap_wr.size() && i < exp_wr.size(); i++) begin
            checks++; if (cap_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rnd_wr[%0d]: got %0h want %0h", i, cap_wr[i], exp_wr[i]); end
        end
        checks++; if (layer_type !== layer_m) begin errors++; $display("FAIL rnd_layer: got %0h want %0h", layer_type, layer_m); end
        checks++; if ({err, err_code} !== {code_m != 2'd0, code_m}) begin errors++; $display("FAIL rnd_err: got err=%0h code=%0h want code=%0h", err, err_code, code_m); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy: got %0h want 0", busy); end
    endtask

    initial begin
        bus.ins_valid = 1'b0;
        bus.ins = '0;
        test_reset();
        test_cfg_rd();
        test_illegal();
        test_max_out();
        test_sync();
        test_stall();
        test_back_to_back();
        test_underflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
